pipe_sequencer: RTL and testbench

- Pipeline control for the CPU core: generates per-stage stall and flush for IF/ID/EX/MEM from bus-busy, load-hazard and MEM-stage exception/EXRT events.
- Sequences exception entry and return: selects the restart PC, writes EPC, holds a one-cycle drain state.
- Sits beside the decoder and pipeline registers; consumes the decoder's `ld_hazard` and the MEM-stage copy of the decoder's `exp_code`/`ctrl_op`.

---
 rtl/pipe_sequencer.sv | 143 ++++++++++++++
 tb/tb_pipe_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_sequencer
// Purpose  : Per-stage stall/flush control plus exception entry/return
//            sequencing (RUN -> DRAIN -> RUN). Optional performance counters
//            are enabled by defining PIPE_SEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_sequencer #(
    parameter logic [29:0] EXP_VECTOR = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic        ld_hazard,
    input  logic        mem_en,
    input  logic [29:0] mem_pc,
    input  logic [2:0]  mem_exp_code,
    input  logic [1:0]  mem_ctrl_op,
    input  logic        irq,
    input  logic        int_en,
    input  logic [29:0] epc_in,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic [29:0] new_pc,
    output logic        epc_we,
    output logic [29:0] epc_out,
    output logic [2:0]  exp_cause,
    output logic        exp_pulse,
    output logic        exrt_pulse,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] c_OP_EXRT = 2'd2;

    state_t      state_q, state_d;
    logic [2:0]  exp_cause_q, exp_cause_d;
    logic [29:0] new_pc_q, new_pc_d;
    logic [3:0]  stall_v, flush_v;

    logic take_exp, take_int, take_rt;
    assign take_exp = mem_en && (mem_exp_code != 3'd0);
    assign take_int = mem_en && irq && int_en;
    assign take_rt  = mem_en && (mem_ctrl_op == c_OP_EXRT);

    always_comb begin
        state_d     = state_q;
        exp_cause_d = exp_cause_q;
        new_pc_d    = new_pc_q;
        stall_v     = 4'b0000;
        flush_v     = 4'b0000;
        new_pc      = 30'h0;
        epc_we      = 1'b0;
        epc_out     = 30'h0;
        exp_pulse   = 1'b0;
        exrt_pulse  = 1'b0;
        // Outputs are forced quiet while reset is held, independent of inputs.
        if (reset) begin
            unique case (state_q)
                RUN: begin
                    if (!mem_busy && (take_exp || take_int)) begin
                        flush_v     = 4'b1111;
                        new_pc      = EXP_VECTOR;
                        new_pc_d    = EXP_VECTOR;
                        epc_we      = 1'b1;
                        epc_out     = mem_pc;
                        exp_pulse   = 1'b1;
                        exp_cause_d = take_exp ? mem_exp_code : 3'd1;
                        state_d     = DRAIN;
                    end else if (!mem_busy && take_rt) begin
                        flush_v    = 4'b1111;
                        new_pc     = epc_in;
                        new_pc_d   = epc_in;
                        exrt_pulse = 1'b1;
                        state_d    = DRAIN;
                    end else if (if_busy || mem_busy) begin
                        stall_v = 4'b1111;
                    end else if (ld_hazard) begin
                        stall_v = 4'b1000;
                        flush_v = 4'b0100;
                    end
                end
                DRAIN: begin
                    flush_v = 4'b1111;
                    new_pc  = new_pc_q;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign {if_stall, id_stall, ex_stall, mem_stall} = stall_v;
    assign {if_flush, id_flush, ex_flush, mem_flush} = flush_v;
    assign exp_cause = exp_cause_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            exp_cause_q <= 3'd0;
            new_pc_q    <= 30'h0;
        end else begin
            state_q     <= state_d;
            exp_cause_q <= exp_cause_d;
            new_pc_q    <= new_pc_d;
        end
    end

`ifdef PIPE_SEQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (|stall_v) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (|flush_v) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_sequencer
// Purpose  : Cycle-by-cycle vector table plus reset-in-DRAIN sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_sequencer;

    localparam logic [29:0] c_EXPV = 30'h0000_0200;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_busy, mem_busy, ld_hazard, mem_en, irq, int_en;
    logic [29:0] mem_pc, epc_in;
    logic [2:0]  mem_exp_code;
    logic [1:0]  mem_ctrl_op;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc, epc_out;
    logic        epc_we, exp_pulse, exrt_pulse;
    logic [2:0]  exp_cause;
    logic [31:0] stall_cnt, flush_cnt;

    pipe_sequencer #(.EXP_VECTOR(c_EXPV)) dut (
        .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
        .ld_hazard(ld_hazard), .mem_en(mem_en), .mem_pc(mem_pc),
        .mem_exp_code(mem_exp_code), .mem_ctrl_op(mem_ctrl_op), .irq(irq),
        .int_en(int_en), .epc_in(epc_in),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc(new_pc), .epc_we(epc_we), .epc_out(epc_out), .exp_cause(exp_cause),
        .exp_pulse(exp_pulse), .exrt_pulse(exrt_pulse),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ib, mb, lh, en, irq, ie;
        logic [29:0] pc, epc;
        logic [2:0]  code;
        logic [1:0]  op;
        logic [3:0]  stl, fl;
        logic [29:0] npc, eo;
        logic        we, ep, rp;
        logic [2:0]  cause;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic ib, mb, lh, en, input logic [29:0] pc,
                        input logic [2:0] code, input logic [1:0] op,
                        input logic irq_v, ie, input logic [29:0] epc,
                        input logic [3:0] stl, fl, input logic [29:0] npc,
                        input logic we, input logic [29:0] eo,
                        input logic ep, rp, input logic [2:0] cause);
        vec_t v;
        v.ib = ib; v.mb = mb; v.lh = lh; v.en = en; v.pc = pc; v.code = code;
        v.op = op; v.irq = irq_v; v.ie = ie; v.epc = epc; v.stl = stl; v.fl = fl;
        v.npc = npc; v.we = we; v.eo = eo; v.ep = ep; v.rp = rp; v.cause = cause;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        if_busy = v.ib; mem_busy = v.mb; ld_hazard = v.lh; mem_en = v.en;
        mem_pc = v.pc; mem_exp_code = v.code; mem_ctrl_op = v.op;
        irq = v.irq; int_en = v.ie; epc_in = v.epc;
    endtask

    task automatic check_outs(input string name, input logic [3:0] stl, fl,
                              input logic [29:0] npc, input logic we,
                              input logic [29:0] eo, input logic ep, rp,
                              input logic [2:0] cause);
        logic [73:0] act, exp;
        act = {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush,
               mem_flush, new_pc, epc_we, epc_out, exp_pulse, exrt_pulse, exp_cause};
        exp = {stl, fl, npc, we, eo, ep, rp, cause};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        logic [31:0] exp_sc, exp_fc;

        idle = '{default: '0};
        //    ib mb lh en pc       cd   op   irq ie epc      stl      fl       npc      we eo       ep rp cause
        push(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 0, 30'h0,   4'b0000, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd0);
        push(0, 0, 1, 0, 30'h0,   3'd0, 2'd0, 0, 0, 30'h0,   4'b1000, 4'b0100, 30'h0,   0, 30'h0,   0, 0, 3'd0);
        push(1, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 0, 30'h0,   4'b1111, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd0);
        push(0, 1, 0, 1, 30'h123, 3'd6, 2'd0, 0, 0, 30'h0,   4'b1111, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd0);
        push(0, 1, 0, 1, 30'h123, 3'd6, 2'd0, 0, 0, 30'h0,   4'b1111, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd0);
        push(0, 1, 0, 1, 30'h123, 3'd6, 2'd0, 0, 0, 30'h0,   4'b1111, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd0);
        push(0, 0, 0, 1, 30'h123, 3'd6, 2'd0, 0, 0, 30'h0,   4'b0000, 4'b1111, c_EXPV,  1, 30'h123, 1, 0, 3'd0);
        push(0, 0, 0, 1, 30'h123, 3'd6, 2'd0, 0, 0, 30'h0,   4'b0000, 4'b1111, c_EXPV,  0, 30'h0,   0, 0, 3'd6);
        push(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 0, 30'h0,   4'b0000, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd6);
        push(0, 0, 0, 1, 30'h40,  3'd2, 2'd0, 1, 1, 30'h0,   4'b0000, 4'b1111, c_EXPV,  1, 30'h40,  1, 0, 3'd6);
        push(0, 0, 0, 1, 30'h44,  3'd0, 2'd0, 1, 1, 30'h0,   4'b0000, 4'b1111, c_EXPV,  0, 30'h0,   0, 0, 3'd2);
        push(0, 0, 0, 1, 30'h48,  3'd0, 2'd0, 1, 1, 30'h0,   4'b0000, 4'b1111, c_EXPV,  1, 30'h48,  1, 0, 3'd2);
        push(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 0, 30'h0,   4'b0000, 4'b1111, c_EXPV,  0, 30'h0,   0, 0, 3'd1);
        push(0, 0, 1, 1, 30'h50,  3'd0, 2'd2, 0, 0, 30'h100, 4'b0000, 4'b1111, 30'h100, 0, 30'h0,   0, 1, 3'd1);
        push(0, 0, 0, 1, 30'h54,  3'd0, 2'd2, 0, 0, 30'h100, 4'b0000, 4'b1111, 30'h100, 0, 30'h0,   0, 0, 3'd1);
        push(0, 0, 0, 1, 30'h58,  3'd0, 2'd0, 1, 0, 30'h0,   4'b0000, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd1);
        push(0, 0, 0, 0, 30'h5C,  3'd7, 2'd0, 1, 1, 30'h0,   4'b0000, 4'b0000, 30'h0,   0, 30'h0,   0, 0, 3'd1);
        push(0, 0, 1, 0, 30'h60,  3'd0, 2'd2, 0, 0, 30'h0,   4'b1000, 4'b0100, 30'h0,   0, 30'h0,   0, 0, 3'd1);
        push(1, 0, 1, 1, 30'h7,   3'd3, 2'd0, 0, 0, 30'h0,   4'b0000, 4'b1111, c_EXPV,  1, 30'h7,   1, 0, 3'd1);
        push(0, 0, 0, 0, 30'h0,   3'd0, 2'd0, 0, 0, 30'h0,   4'b0000, 4'b1111, c_EXPV,  0, 30'h0,   0, 0, 3'd3);

        // Reset held with an exception on the inputs: everything quiet.
        reset = 1'b0;
        drive(vq[6]);
        if_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outs("reset_state", 4'b0, 4'b0, 30'h0, 1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        check32("reset_stall_cnt", stall_cnt, 32'h0);
        check32("reset_flush_cnt", flush_cnt, 32'h0);
        drive(idle);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check_outs($sformatf("vec%0d", i), vq[i].stl, vq[i].fl, vq[i].npc,
                       vq[i].we, vq[i].eo, vq[i].ep, vq[i].rp, vq[i].cause);
        end

        @(negedge clk);
        drive(idle);
`ifdef PIPE_SEQ_PERF_CNT_EN
        exp_sc = 32'd6;
        exp_fc = 32'd12;
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        #1;
        check32("stall_cnt", stall_cnt, exp_sc);
        check32("flush_cnt", flush_cnt, exp_fc);

        // Reset asserted while in DRAIN.
        @(negedge clk);
        mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h99;
        #1;
        check_outs("pre_rst_entry", 4'b0, 4'b1111, c_EXPV, 1'b1, 30'h99, 1'b1, 1'b0, 3'd3);
        @(negedge clk);
        #1;
        check_outs("pre_rst_drain", 4'b0, 4'b1111, c_EXPV, 1'b0, 30'h0, 1'b0, 1'b0, 3'd5);
        reset = 1'b0;
        #1;
        check_outs("rst_in_drain", 4'b0, 4'b0, 30'h0, 1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        check32("rst_stall_cnt", stall_cnt, 32'h0);
        check32("rst_flush_cnt", flush_cnt, 32'h0);
        @(negedge clk);
        drive(idle);
        ld_hazard = 1'b1;
        reset = 1'b1;
        #1;
        check_outs("run_after_rst", 4'b1000, 4'b0100, 30'h0, 1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        drive(idle);
        #1;
        check_outs("idle_after_rst", 4'b0, 4'b0, 30'h0, 1'b0, 30'h0, 1'b0, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
